ctc_word_timing: RTL and testbench
==================================

Name: ctc_word_timing

Overview:
- Upstream timing/control stage that feeds the A&R block its `is`, `ws` and `sync` serial signals.
- Owns the 56-bit-time word counter and a one-entry instruction buffer.
- Serializes each 10-bit instruction onto `is` during T45..T54.
- During the following word cycle it generates the word-select (`ws`) window from the field code and the pointer register P, and samples the A&R `carry` result into a condition flag.

Parameters:
- WORD_BITS, 56, bit times per word cycle (T0..T55).
- SYNC_FIRST, 45, first bit time of the sync/`is` window (window is SYNC_FIRST..SYNC_FIRST+9).
- P_RESET, 0, pointer value after reset.

Ports:
- cph2  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  10  instruction word; [1:0]=type, [4:2]=field, [9:5]=opcode.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  buffer can accept; transfer occurs when valid&&ready.
- carry  input  1  carry/compare result from A&R.
- sync  output  1  high during T45..T54.
- is  output  1  serial instruction bit, LSB first.
- ws  output  1  word-select window for the executing instruction.
- cond  output  1  carry latched at end of an executed arithmetic word cycle.
- ptr  output  4  current pointer P.
- t0  output  1  high when cnt==0.

Behaviour:
- Reset values (async, immediate): cnt=0, sync=0, is=0, ws=0, cond=0, ptr=P_RESET, t0=1, instr_ready=1, buffer empty.
  - After reset, the shift and execute registers hold NOP (10'b0); the first word cycle executes NOP.
- Counter: cnt 0..55, increments every cycle, wraps 55->0. t0 = (cnt==0).
- Buffer: one entry.
  - instr_ready = !full || (cnt==44).
  - Accept when valid&&ready; this sets full.
  - At cnt==44 the buffer (or NOP if empty) moves to the shift register and full clears; an accept in the same cycle refills it.
- Serialization:
  - sync=1 exactly for cnt 45..54.
  - is = shift[cnt-45] for cnt 45..54 (bit0 at T45, bit9 at T54), 0 otherwise.
  - Both are registered so they change on the edge entering the bit time.
  - sync falls at T55, so the A&R counter realigns to our T0.
- Execute register: loaded from the shift register at cnt==55; governs ws/P/cond for the next 56 bit times.
- ws (type 2'b10 only, else 0): digit d = cnt[5:2]; ws=1 on all 4 bit times of each selected digit. Field codes:
  - 000 P: d==P
  - 001 M: 3..12
  - 010 X: 0..1
  - 011 W: 0..13
  - 100 WP: 0..P
  - 101 MS: 3..13
  - 110 XS: d==2
  - 111 S: d==13
  - Digits 14..15 (cnt 56..63) never occur.
  - If P>13, the P and WP fields select no digit beyond 13.
- Pointer:
  - Type 2'b01: P=instr[9:6], taking effect at cnt==55 of the executing word cycle.
  - Values 14/15 are stored as given.
- cond: at cnt==55 of an executing type 2'b10 word, cond<=carry; other types leave cond unchanged.
- Reset mid-word: all state reverts immediately; any partially shifted or buffered instruction is discarded.

Optional Feature:
- CTC_PTR_INCDEC_EN
  - Defined: type 2'b11 adjusts P at cnt==55. instr[2]=0 gives P+1 with 13->0 wrap; instr[2]=1 gives P-1 with 0->13 wrap. ws stays 0.
  - Undefined: type 2'b11 is a no-op; P unchanged, ws 0.

Test Plan:
- Release reset, no valid -> sync high for cnt 45..54, is=0 throughout, ws=0 for the first two words, instr_ready=1.
- Push 10'b1011001110 at cnt=10 -> is sequence T45..T54 = 0,1,1,1,0,0,1,1,0,1; instr_ready=0 until cnt 44.
- Arith field W (instr[4:2]=011, type 10) -> next word ws=1 for cnt 0..55; field XS -> ws=1 only cnt 8..11.
- Type 01 with instr[9:6]=5, then arith field WP -> ws=1 for cnt 0..23; field P -> cnt 20..23.
- Arith instr with carry=1 at T55 -> cond=1 from next T0; subsequent type 00 word with carry=0 -> cond stays 1.
- Assert rst_n=0 at cnt=50 mid-shift -> sync/is/ws drop at once, ptr=0; after release the queued instruction is lost and NOP executes.
- With CTC_PTR_INCDEC_EN: P=13 then type 11 instr[2]=0 -> ptr=0; P=0 then instr[2]=1 -> ptr=13.

Source files
------------

// File: rtl/ctc_word_timing.sv
// ctc_word_timing: 56-bit-time word counter, one-entry instruction buffer, is/sync serializer, ws/P/cond execute stage.
// Latency: an instruction accepted in word N is serialized at T45..T54 of word N and executes in word N+1.
// Backpressure: instr_ready drops while the buffer is full and reopens at T44. Build option: CTC_PTR_INCDEC_EN (type 11 adjusts P).
module ctc_word_timing #(
  parameter int WORD_BITS  = 56,
  parameter int SYNC_FIRST = 45,
  parameter int P_RESET    = 0
) (
  input  logic       cph2,
  input  logic       rst_n,
  input  logic [9:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       carry,
  output logic       sync,
  output logic       is,
  output logic       ws,
  output logic       cond,
  output logic [3:0] ptr,
  output logic       t0
);

  localparam logic [5:0] L_LAST   = 6'(WORD_BITS - 1);
  localparam logic [5:0] L_LOAD   = 6'(SYNC_FIRST - 1);
  localparam logic [5:0] L_SFIRST = 6'(SYNC_FIRST);
  localparam logic [5:0] L_SLAST  = 6'(SYNC_FIRST + 9);
  localparam logic [1:0] TY_PTR   = 2'b01;
  localparam logic [1:0] TY_ARITH = 2'b10;

  logic [5:0] r_cnt;
  logic       r_full;
  logic [9:0] r_buf;
  logic [9:0] r_shift;
  logic [9:0] r_exec;
  logic [3:0] r_ptr;
  logic       r_cond;
  logic       r_sync;
  logic       r_is;

  logic [5:0] w_cnt_nxt;
  logic       w_load;
  logic       w_wrap;
  logic       w_accept;
  logic [9:0] w_shift_nxt;
  logic       w_win_nxt;
  logic [3:0] w_idx;
  logic [3:0] w_digit;
  logic       w_ws;
  logic [3:0] w_ptr_nxt;
  logic       w_unused;

  assign w_wrap      = (r_cnt == L_LAST);
  assign w_load      = (r_cnt == L_LOAD);
  assign w_cnt_nxt   = w_wrap ? 6'd0 : r_cnt + 6'd1;
  assign instr_ready = !r_full || w_load;
  assign w_accept    = instr_valid && instr_ready;
  // An empty buffer at T44 hands a NOP to the serializer.
  assign w_shift_nxt = w_load ? (r_full ? r_buf : 10'b0) : r_shift;
  assign w_win_nxt   = (w_cnt_nxt >= L_SFIRST) && (w_cnt_nxt <= L_SLAST);
  assign w_idx       = 4'(w_cnt_nxt - L_SFIRST);
  assign w_digit     = r_cnt[5:2];
  // Opcode bit 5 is not decoded by this stage.
  assign w_unused    = r_exec[5];

  assign t0   = (r_cnt == 6'd0);
  assign sync = r_sync;
  assign is   = r_is;
  assign ws   = w_ws;
  assign cond = r_cond;
  assign ptr  = r_ptr;

  // Bit-time counter, wraps at the end of the word.
  always_ff @(posedge cph2 or negedge rst_n) begin
    if (!rst_n) r_cnt <= 6'd0;
    else        r_cnt <= w_cnt_nxt;
  end

  // One-entry buffer: drained at T44, refilled by any accept in the same cycle.
  always_ff @(posedge cph2 or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_buf  <= 10'b0;
    end else begin
      if (w_load)   r_full <= 1'b0;
      if (w_accept) begin
        r_full <= 1'b1;
        r_buf  <= instr;
      end
    end
  end

  // Serializer: sync/is registered from the next count so they switch on entering the bit time.
  always_ff @(posedge cph2 or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 10'b0;
      r_sync  <= 1'b0;
      r_is    <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_sync  <= w_win_nxt;
      r_is    <= w_win_nxt ? w_shift_nxt[w_idx] : 1'b0;
    end
  end

  // Word-select window decode for arithmetic instructions; digits never exceed 13 in a 56-bit word.
  always_comb begin
    w_ws = 1'b0;
    if (r_exec[1:0] == TY_ARITH) begin
      case (r_exec[4:2])
        3'b000:  w_ws = (w_digit == r_ptr);
        3'b001:  w_ws = (w_digit >= 4'd3) && (w_digit <= 4'd12);
        3'b010:  w_ws = (w_digit <= 4'd1);
        3'b011:  w_ws = (w_digit <= 4'd13);
        3'b100:  w_ws = (w_digit <= r_ptr) && (w_digit <= 4'd13);
        3'b101:  w_ws = (w_digit >= 4'd3) && (w_digit <= 4'd13);
        3'b110:  w_ws = (w_digit == 4'd2);
        default: w_ws = (w_digit == 4'd13);
      endcase
    end
  end

  // Pointer update applied at the last bit time of the executing word.
  always_comb begin
    w_ptr_nxt = r_ptr;
    case (r_exec[1:0])
      TY_PTR:  w_ptr_nxt = r_exec[9:6];
`ifdef CTC_PTR_INCDEC_EN
      2'b11:   w_ptr_nxt = r_exec[2] ? ((r_ptr == 4'd0)  ? 4'd13 : r_ptr - 4'd1)
                                     : ((r_ptr == 4'd13) ? 4'd0  : r_ptr + 4'd1);
`endif
      default: w_ptr_nxt = r_ptr;
    endcase
  end

  // Execute stage: load next instruction, commit pointer and carry flag at T55.
  always_ff @(posedge cph2 or negedge rst_n) begin
    if (!rst_n) begin
      r_exec <= 10'b0;
      r_ptr  <= 4'(P_RESET);
      r_cond <= 1'b0;
    end else if (w_wrap) begin
      r_exec <= r_shift;
      r_ptr  <= w_ptr_nxt;
      if (r_exec[1:0] == TY_ARITH) r_cond <= carry;
    end
  end

endmodule

// File: tb/tb_ctc_word_timing.sv
// Bench for ctc_word_timing: word-level reference model plus directed literal checks and random traffic.
module tb_ctc_word_timing;
  logic       cph2 = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] instr = 10'b0;
  logic       instr_valid = 1'b0;
  logic       carry = 1'b0;
  logic       instr_ready, sync, is, ws, cond, t0;
  logic [3:0] ptr;

  always #5 cph2 = ~cph2;

  ctc_word_timing dut (
    .cph2(cph2), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .carry(carry), .sync(sync), .is(is), .ws(ws),
    .cond(cond), .ptr(ptr), .t0(t0)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: bit time, pending queue, word on the serial line, word executing.
  int         m_cnt;
  logic [9:0] m_q[$];
  logic [9:0] m_tx, m_ex;
  logic [3:0] m_p;
  logic       m_cond;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t cnt=%0d", nm, act, exp, $time, m_cnt);
    end
  endtask

  function automatic bit m_ready();
    return (m_q.size() == 0) || (m_cnt == 44);
  endfunction

  function automatic bit exp_ws(input logic [9:0] ex, input logic [3:0] p, input int c);
    int d, lo, hi;
    d = c / 4;
    if (ex[1:0] != 2'b10) return 1'b0;
    case (ex[4:2])
      3'd0: begin lo = p;  hi = p;  end
      3'd1: begin lo = 3;  hi = 12; end
      3'd2: begin lo = 0;  hi = 1;  end
      3'd3: begin lo = 0;  hi = 13; end
      3'd4: begin lo = 0;  hi = p;  end
      3'd5: begin lo = 3;  hi = 13; end
      3'd6: begin lo = 2;  hi = 2;  end
      default: begin lo = 13; hi = 13; end
    endcase
    return (d >= lo) && (d <= hi) && (d <= 13);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_q.delete(); m_tx = '0; m_ex = '0; m_p = '0; m_cond = 1'b0;
  endtask

  task automatic model_tick();
    bit acc;
    acc = instr_valid && m_ready();
    if (m_cnt == 55) begin
      if (m_ex[1:0] == 2'b01) m_p = m_ex[9:6];
`ifdef CTC_PTR_INCDEC_EN
      if (m_ex[1:0] == 2'b11)
        m_p = m_ex[2] ? ((m_p == 0) ? 4'd13 : m_p - 4'd1) : ((m_p == 13) ? 4'd0 : m_p + 4'd1);
`endif
      if (m_ex[1:0] == 2'b10) m_cond = carry;
      m_ex = m_tx;
    end
    if (m_cnt == 44) m_tx = (m_q.size() != 0) ? m_q.pop_front() : 10'b0;
    if (acc) m_q.push_back(instr);
    m_cnt = (m_cnt + 1) % 56;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge cph2) begin
    if (chk_en) begin
      check("t0", t0, m_cnt == 0);
      check("sync", sync, (m_cnt >= 45) && (m_cnt <= 54));
      check("is", is, ((m_cnt >= 45) && (m_cnt <= 54)) ? m_tx[m_cnt-45] : 1'b0);
      check("ws", ws, exp_ws(m_ex, m_p, m_cnt));
      check("cond", cond, m_cond);
      check("ptr", ptr, m_p);
      check("instr_ready", instr_ready, m_ready());
    end
  end

  task automatic cyc();
    @(posedge cph2);
    if (rst_n) model_tick();
    @(negedge cph2);
    #1;
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (m_cnt != c && n < 200) begin
      cyc();
      n++;
    end
    if (m_cnt != c) begin
      total++; bad++;
      $display("FAIL wait_cnt: timed out waiting for cnt %0d, at %0d", c, m_cnt);
    end
  endtask

  task automatic push(input logic [9:0] v);
    wait_cnt(10);
    instr = v; instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0; instr = 10'b0;
  endtask

  task automatic run_instr(input logic [9:0] v);
    push(v);
    wait_cnt(55); cyc();
    wait_cnt(55); cyc();
  endtask

  task automatic cap_ws(output logic [55:0] m);
    wait_cnt(0);
    m = '0;
    for (int i = 0; i < 56; i++) begin
      m[i] = ws;
      cyc();
    end
  endtask

  initial begin
    logic [55:0] m;
    logic [9:0]  v;
    int ns;
    model_reset();
    chk_en = 1'b1;
    cyc();
    check("rst_t0", t0, 1'b1);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_ptr", ptr, 4'd0);
    check("rst_sync", sync, 1'b0);
    rst_n = 1'b1;

    // Idle words: sync window only, no word select.
    ns = 0;
    wait_cnt(0);
    for (int i = 0; i < 56; i++) begin
      ns += int'(sync);
      cyc();
    end
    check("idle_sync_count", ns, 10);
    cap_ws(m);
    check("idle_ws", m, 56'h0);

    // Serialization of a W-field arithmetic instruction, then its window.
    push(10'b1011001110);
    check("ready_held", instr_ready, 1'b0);
    wait_cnt(45);
    for (int i = 0; i < 10; i++) begin
      v[i] = is;
      cyc();
    end
    check("is_seq", v, 10'b1011001110);
    cap_ws(m);
    check("ws_W", m, 56'hFF_FFFF_FFFF_FFFF);

    push(10'b0000011010);
    cap_ws(m);
    check("ws_XS", m, 56'h0000_0000_0000_F00);

    // Pointer load, then P-relative fields.
    push(10'b0101000001);
    push(10'b0000010010);
    cap_ws(m);
    check("ws_WP", m, 56'h00_0000_00FF_FFFF);
    check("ptr_5", ptr, 4'd5);
    push(10'b0000000010);
    cap_ws(m);
    check("ws_P", m, 56'h00_0000_00F0_0000);

    // Carry capture at T55 of an arithmetic word, held through a non-arithmetic word.
    push(10'b0000001110);
    wait_cnt(55); cyc();
    wait_cnt(55);
    carry = 1'b1;
    cyc();
    carry = 1'b0;
    check("cond_set", cond, 1'b1);
    run_instr(10'b1111100100);
    check("cond_hold", cond, 1'b1);

`ifdef CTC_PTR_INCDEC_EN
    push(10'b1101000001);
    run_instr(10'b0000000011);
    check("ptr_inc_wrap", ptr, 4'd0);
    run_instr(10'b0000000111);
    check("ptr_dec_wrap", ptr, 4'd13);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr = 10'($urandom);
      carry = 1'($urandom_range(0, 1));
      cyc();
    end
    instr_valid = 1'b0; instr = 10'b0; carry = 1'b0;

    // Reset mid-shift while a W window is active; the queued instruction is dropped.
    push(10'b0000001110);
    push(10'b1011001110);
    wait_cnt(50);
    check("ws_before_rst", ws, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_sync", sync, 1'b0);
    check("rst_mid_is", is, 1'b0);
    check("rst_mid_ws", ws, 1'b0);
    check("rst_mid_ptr", ptr, 4'd0);
    check("rst_mid_t0", t0, 1'b1);
    cyc(); cyc(); cyc();
    rst_n = 1'b1;
    cap_ws(m);
    check("post_rst_ws0", m, 56'h0);
    cap_ws(m);
    check("post_rst_ws1", m, 56'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
